// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN streaming stages.
//   POOL_MODE_AVG / POOL_MODE_MAX : encodings of the per-frame pooling mode
//   pool_shift(pool)              : right shift that divides a pool*pool window sum
package cnn_pkg;

    localparam logic POOL_MODE_AVG = 1'b0;
    localparam logic POOL_MODE_MAX = 1'b1;

    // log2(pool*pool) for power-of-two window edges.
    function automatic int unsigned pool_shift(input int unsigned pool);
        return 2 * $clog2(pool);
    endfunction

endpackage

// File: rtl/pool_combine.sv
// Combinational pooling operator: folds one pixel into a window accumulator.
//   i_acc    : running accumulator (ACC_W, signed)
//   i_pixel  : incoming pixel (DATA_W, signed, sign-extended internally)
//   i_mode   : POOL_MODE_AVG -> sum, POOL_MODE_MAX -> signed maximum
//   o_result : updated accumulator (ACC_W, signed)
module pool_combine
    import cnn_pkg::*;
#(
    parameter int unsigned ACC_W  = 34,
    parameter int unsigned DATA_W = 32
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [DATA_W-1:0] i_pixel,
    input  logic                     i_mode,
    output logic signed [ACC_W-1:0]  o_result
);

    logic signed [ACC_W-1:0] w_pix_ext;

    assign w_pix_ext = {{(ACC_W - DATA_W){i_pixel[DATA_W-1]}}, i_pixel};

    always_comb begin
        if (i_mode == POOL_MODE_MAX) begin
            o_result = (i_acc > w_pix_ext) ? i_acc : w_pix_ext;
        end else begin
            o_result = i_acc + w_pix_ext;
        end
    end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2-D pooling engine (average or max, stride = window edge).
// Pixels arrive one per cycle in raster order; one pooled pixel leaves per
// POOL x POOL window, also in raster order. Only one accumulator per output
// column is kept, so no line or frame buffer is needed.
//   clk, rst             : clock, asynchronous active-high reset
//   mode                 : 0 = average, 1 = max; latched on the first pixel of a frame
//   clear                : synchronous frame abort (wins over any handshake)
//   in_valid/in_ready    : input pixel handshake, in_data signed DATA_W
//   out_valid/out_ready  : pooled pixel handshake, out_data signed DATA_W
//   frame_done           : one-cycle pulse after the frame's last output is taken
module pool2d_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FM_W   = 6,
    parameter int unsigned FM_H   = 6,
    parameter int unsigned POOL   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     frame_done
);

    localparam int unsigned ACC_W  = DATA_W + 2 * $clog2(POOL);
    localparam int unsigned NWIN   = FM_W / POOL;
    localparam int unsigned PL     = $clog2(POOL);
    localparam int unsigned CW     = $clog2(FM_W);
    localparam int unsigned RW     = $clog2(FM_H);
    localparam int unsigned WIDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int unsigned SHIFT  = pool_shift(POOL);

    if ((FM_W % POOL) != 0 || (FM_H % POOL) != 0 || !(POOL == 2 || POOL == 4)) begin : g_cfg_error
        $fatal(1, "pool2d_stream: FM_W/FM_H must be multiples of POOL, POOL must be 2 or 4");
    end

    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic                      r_mode_q;
    logic                      r_out_valid;
    logic signed [DATA_W-1:0]  r_out_data;
    logic                      r_out_last;
    logic                      r_frame_done;
    logic signed [ACC_W-1:0]   r_acc [NWIN];

    logic                      w_accept;
    logic                      w_out_hs;
    logic [WIDX_W-1:0]         w_widx;
    logic                      w_first;
    logic                      w_last;
    logic                      w_col_end;
    logic                      w_row_end;
    logic signed [ACC_W-1:0]   w_pix_ext;
    logic signed [ACC_W-1:0]   w_comb;
    logic signed [DATA_W-1:0]  w_out_next;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    // POOL is a power of two, so col/POOL and col%POOL are plain bit fields.
    assign w_widx     = WIDX_W'(r_col >> PL);
    assign w_first    = (r_row[PL-1:0] == '0) && (r_col[PL-1:0] == '0);
    assign w_last     = (&r_row[PL-1:0]) && (&r_col[PL-1:0]);
    assign w_col_end  = (r_col == CW'(FM_W - 1));
    assign w_row_end  = (r_row == RW'(FM_H - 1));
    assign w_pix_ext  = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};

    pool_combine #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_combine (
        .i_acc    (r_acc[w_widx]),
        .i_pixel  (in_data),
        .i_mode   (r_mode_q),
        .o_result (w_comb)
    );

    // Arithmetic shift floors toward -inf; the quotient always fits DATA_W.
    always_comb begin
        if (r_mode_q == POOL_MODE_MAX) begin
            w_out_next = DATA_W'(w_comb);
        end else begin
            w_out_next = DATA_W'(w_comb >>> SHIFT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_mode_q     <= POOL_MODE_AVG;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_hs && r_out_last;
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (r_col == '0 && r_row == '0) begin
                    r_mode_q <= mode;
                end
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                // A new result overrides the clear-on-handshake above.
                if (w_last) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_out_next;
                    r_out_last  <= w_col_end && w_row_end;
                end
            end
        end
    end

    // Accumulator contents are don't-care after reset: every window starts with a load.
    always_ff @(posedge clk) begin
        if (w_accept && !clear) begin
            r_acc[w_widx] <= w_first ? w_pix_ext : w_comb;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench for pool2d_stream: instance a is 6x6 / POOL=2, instance b
// is 8x8 / POOL=4. Fixed vectors, hand-written corner sequences and random
// frames checked against a window-arithmetic reference model.
module tb_pool2d_stream;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst       [2];
    logic              mode      [2];
    logic              clear     [2];
    logic              in_valid  [2];
    logic signed [DW-1:0] in_data [2];
    logic              out_ready [2];
    logic              rand_bp   [2];
    logic              rdy_cmd   [2];

    logic              a_in_ready, a_out_valid, a_frame_done;
    logic signed [DW-1:0] a_out_data;
    logic              b_in_ready, b_out_valid, b_frame_done;
    logic signed [DW-1:0] b_out_data;

    pool2d_stream #(.DATA_W(DW), .FM_W(6), .FM_H(6), .POOL(2)) u_dut_a (
        .clk(clk), .rst(rst[0]), .mode(mode[0]), .clear(clear[0]),
        .in_valid(in_valid[0]), .in_ready(a_in_ready), .in_data(in_data[0]),
        .out_valid(a_out_valid), .out_ready(out_ready[0]), .out_data(a_out_data),
        .frame_done(a_frame_done)
    );

    pool2d_stream #(.DATA_W(DW), .FM_W(8), .FM_H(8), .POOL(4)) u_dut_b (
        .clk(clk), .rst(rst[1]), .mode(mode[1]), .clear(clear[1]),
        .in_valid(in_valid[1]), .in_ready(b_in_ready), .in_data(in_data[1]),
        .out_valid(b_out_valid), .out_ready(out_ready[1]), .out_data(b_out_data),
        .frame_done(b_frame_done)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int stall_cnt [2];

    logic signed [DW-1:0] got0 [$];
    logic signed [DW-1:0] got1 [$];
    int fd0 = 0, fd1 = 0, fd_cyc0 = 0, hs_cyc0 = 0;

    logic signed [DW-1:0] frame [$];
    logic                 md_q  [$];
    int                   exp_q [$];

    typedef struct {
        string                name;
        logic                 md;
        logic signed [DW-1:0] w0, w1, w2, w3;
        logic signed [DW-1:0] exp;
    } vec_t;
    vec_t tbl [7];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes become effective at the next rising edge; record them at the falling edge.
    always @(negedge clk) begin
        if (!rst[0] && !clear[0] && a_out_valid && out_ready[0]) begin
            got0.push_back(a_out_data);
            hs_cyc0 = cyc;
        end
        if (a_frame_done) begin
            fd0++;
            fd_cyc0 = cyc;
        end
    end

    always @(negedge clk) begin
        if (!rst[1] && !clear[1] && b_out_valid && out_ready[1]) got1.push_back(b_out_data);
        if (b_frame_done) fd1++;
    end

    initial begin
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int s = 0; s < 2; s++)
                out_ready[s] = rand_bp[s] ? 1'($urandom_range(0, 1)) : rdy_cmd[s];
        end
    end

    function automatic logic rdy_of(input int s);
        return (s != 0) ? b_in_ready : a_in_ready;
    endfunction

    function automatic int gsize(input int s);
        return (s != 0) ? got1.size() : got0.size();
    endfunction

    function automatic longint gval(input int s, input int i);
        return (s != 0) ? longint'(got1[i]) : longint'(got0[i]);
    endfunction

    task automatic flush(input int s);
        if (s != 0) got1.delete();
        else got0.delete();
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel was taken.
    task automatic send_px(input int s, input logic signed [DW-1:0] px);
        int waited = 0;
        in_valid[s] = 1'b1;
        in_data[s]  = px;
        @(negedge clk);
        while (!rdy_of(s) && waited < 60) begin
            waited++;
            stall_cnt[s]++;
            @(negedge clk);
        end
        if (!rdy_of(s)) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_all(input int s);
        for (int i = 0; i < frame.size(); i++) begin
            mode[s] = md_q[i];
            send_px(s, frame[i]);
        end
        in_valid[s] = 1'b0;
    endtask

    task automatic build_ramp(input int n, input logic md);
        frame.delete();
        md_q.delete();
        for (int i = 0; i < n; i++) begin
            frame.push_back(DW'(i));
            md_q.push_back(md);
        end
    endtask

    task automatic wait_out(input int s, input int n);
        int b = 0;
        while (gsize(s) < n && b < 400) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_frame(input int s, input string name);
        chk({name, " count"}, gsize(s), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < gsize(s); i++)
            chk($sformatf("%s[%0d]", name, i), gval(s, i), exp_q[i]);
        flush(s);
    endtask

    // Reference: every window of every frame in 'frame', mode taken from the frame's first pixel.
    task automatic model(input int w, input int h, input int p);
        int nf;
        int base;
        longint sum, mx, v, q;
        nf = frame.size() / (w * h);
        exp_q.delete();
        for (int f = 0; f < nf; f++) begin
            base = f * w * h;
            for (int wr = 0; wr < h / p; wr++) begin
                for (int wc = 0; wc < w / p; wc++) begin
                    sum = 0;
                    mx  = -(longint'(1) << 40);
                    for (int dy = 0; dy < p; dy++) begin
                        for (int dx = 0; dx < p; dx++) begin
                            v = longint'(frame[base + (wr * p + dy) * w + wc * p + dx]);
                            sum += v;
                            if (v > mx) mx = v;
                        end
                    end
                    if (md_q[base]) begin
                        exp_q.push_back(int'(mx));
                    end else begin
                        q = sum / (p * p);
                        if ((sum % (p * p)) != 0 && sum < 0) q = q - 1;
                        exp_q.push_back(int'(q));
                    end
                end
            end
        end
    endtask

    task automatic append_random(input int n, input logic md);
        int r;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                frame.push_back($urandom);
            end else begin
                r = int'($urandom_range(0, 200)) - 100;
                frame.push_back(DW'(r));
            end
            md_q.push_back(md);
        end
    endtask

    initial begin
        int fd_before;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; mode[s] = 1'b0; clear[s] = 1'b0; in_valid[s] = 1'b0;
            in_data[s] = '0; rand_bp[s] = 1'b0; rdy_cmd[s] = 1'b1; stall_cnt[s] = 0;
        end
        tbl[0] = '{"neg_avg",   1'b0, -1, -2, -3, -4, -3};
        tbl[1] = '{"neg_max",   1'b1, -1, -2, -3, -4, -1};
        tbl[2] = '{"ext_max",   1'b1, 32'sh7FFFFFFF, 32'sh80000000, 0, 0, 32'sh7FFFFFFF};
        tbl[3] = '{"pos_sat",   1'b0, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF,
                   32'sh7FFFFFFF};
        tbl[4] = '{"neg_sat",   1'b0, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000,
                   32'sh80000000};
        tbl[5] = '{"floor_pos", 1'b0, 1, 2, 3, 3, 2};
        tbl[6] = '{"floor_neg", 1'b0, -1, 0, 0, 0, -1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid_a", a_out_valid, 0);
        chk("rst_out_data_a", a_out_data, 0);
        chk("rst_frame_done_a", a_frame_done, 0);
        chk("rst_in_ready_a", a_in_ready, 1);
        chk("rst_out_valid_b", b_out_valid, 0);
        chk("rst_out_data_b", b_out_data, 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // Ramp, average: also frame_done count/timing and uninterrupted in_ready.
        build_ramp(36, 1'b0);
        stall_cnt[0] = 0;
        fd_before = fd0;
        send_all(0);
        wait_out(0, 9);
        exp_q = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        compare_frame(0, "ramp_avg");
        chk("ramp_avg_in_ready_stalls", stall_cnt[0], 0);
        chk("ramp_avg_frame_done_count", fd0 - fd_before, 1);
        chk("ramp_avg_frame_done_timing", fd_cyc0, hs_cyc0 + 1);

        build_ramp(36, 1'b1);
        fd_before = fd0;
        send_all(0);
        wait_out(0, 9);
        exp_q = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
        compare_frame(0, "ramp_max");
        chk("ramp_max_frame_done_count", fd0 - fd_before, 1);

        // Single-window vectors, rest of the frame zero.
        for (int k = 0; k < 7; k++) begin
            frame.delete();
            md_q.delete();
            for (int i = 0; i < 36; i++) begin
                frame.push_back('0);
                md_q.push_back(tbl[k].md);
            end
            frame[0] = tbl[k].w0;
            frame[1] = tbl[k].w1;
            frame[6] = tbl[k].w2;
            frame[7] = tbl[k].w3;
            send_all(0);
            wait_out(0, 9);
            if (gsize(0) > 0) chk({tbl[k].name, "_first"}, gval(0, 0), tbl[k].exp);
            else chk({tbl[k].name, "_missing"}, 0, 1);
            model(6, 6, 2);
            compare_frame(0, tbl[k].name);
        end

        // Output stall: first result held for five cycles with input blocked.
        build_ramp(36, 1'b0);
        rdy_cmd[0] = 1'b0;
        @(posedge clk);
        #1;
        fork
            send_all(0);
            begin
                int b = 0;
                @(negedge clk);
                while (!a_out_valid && b < 100) begin
                    @(negedge clk);
                    b++;
                end
                chk("stall_out_valid", a_out_valid, 1);
                for (int k = 0; k < 5; k++) begin
                    chk($sformatf("stall_in_ready[%0d]", k), a_in_ready, 0);
                    chk($sformatf("stall_hold[%0d]", k), a_out_data, 3);
                    @(negedge clk);
                end
                rdy_cmd[0] = 1'b1;
            end
        join
        wait_out(0, 9);
        exp_q = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        compare_frame(0, "stall_frame");

        // Asynchronous reset mid-frame.
        build_ramp(36, 1'b0);
        for (int i = 0; i < 15; i++) send_px(0, DW'(100 + i));
        in_valid[0] = 1'b0;
        rst[0] = 1'b1;
        #2;
        chk("rst_mid_frame_done", a_frame_done, 0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        flush(0);
        send_all(0);
        wait_out(0, 9);
        exp_q = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        compare_frame(0, "after_rst");

        // Clear with a pending output and a simultaneous input pixel.
        for (int i = 0; i < 10; i++) begin
            mode[0] = 1'b1;
            send_px(0, DW'(500 + i));
        end
        rdy_cmd[0] = 1'b0;
        @(negedge clk);
        chk("pre_clear_pending", a_out_valid, 1);
        @(posedge clk);
        #1;
        clear[0]   = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0] = DW'(12345);
        @(posedge clk);
        #1;
        clear[0]   = 1'b0;
        in_valid[0] = 1'b0;
        chk("clear_out_valid", a_out_valid, 0);
        rdy_cmd[0] = 1'b1;
        @(posedge clk);
        #1;
        flush(0);
        build_ramp(36, 1'b0);
        send_all(0);
        wait_out(0, 9);
        compare_frame(0, "after_clear");

        // Mode flips mid-frame are ignored.
        build_ramp(36, 1'b1);
        for (int i = 5; i < 36; i++) md_q[i] = 1'b0;
        send_all(0);
        wait_out(0, 9);
        exp_q = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
        compare_frame(0, "mode_toggle");

        // POOL=4 on 8x8.
        build_ramp(64, 1'b0);
        send_all(1);
        wait_out(1, 4);
        exp_q = '{13, 17, 45, 49};
        compare_frame(1, "p4_ramp_avg");
        build_ramp(64, 1'b1);
        fd_before = fd1;
        send_all(1);
        wait_out(1, 4);
        exp_q = '{27, 31, 59, 63};
        compare_frame(1, "p4_ramp_max");
        chk("p4_frame_done_count", fd1 - fd_before, 1);

        // Random back-to-back frames with random output backpressure.
        for (int s = 0; s < 2; s++) begin
            int npx;
            npx = (s != 0) ? 64 : 36;
            frame.delete();
            md_q.delete();
            for (int f = 0; f < 3; f++) append_random(npx, 1'($urandom_range(0, 1)));
            fd_before = (s != 0) ? fd1 : fd0;
            rand_bp[s] = 1'b1;
            send_all(s);
            wait_out(s, (s != 0) ? 12 : 27);
            rand_bp[s] = 1'b0;
            @(posedge clk);
            #2;
            @(posedge clk);
            #1;
            if (s != 0) model(8, 8, 4);
            else model(6, 6, 2);
            compare_frame(s, $sformatf("rand%0d", s));
            chk($sformatf("rand%0d_frame_done_count", s), ((s != 0) ? fd1 : fd0) - fd_before, 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
Streaming 2-D pooling engine, successor to the fixed 6x6 / 2x2 average pool stage in cnn_core. Accepts one feature-map pixel per cycle in raster order over a valid/ready handshake. Emits one pooled pixel per POOLxPOOL window (stride = POOL), also in raster order. Pooling mode (average or max) is selected per frame. Buffering is a per-output-column accumulator row rather than full line buffers, so the block sits directly between the conv stage and the dense/next-layer stage with no frame RAM.

Parameters:
DATA_W, 32, signed pixel width (input and output)
FM_W, 6, feature-map width in pixels; must be a multiple of POOL
FM_H, 6, feature-map height in pixels; must be a multiple of POOL
POOL, 2, window edge and stride; must be 2 or 4
ACC_W, DATA_W+2*$clog2(POOL), accumulator width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mode  in  1  0 = average, 1 = max; sampled when the first pixel of a frame is accepted
clear  in  1  synchronous frame abort; returns the block to the start-of-frame state
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept an input pixel
in_data  in  DATA_W  signed input pixel
out_valid  out  1  pooled pixel valid
out_ready  in  1  downstream accepts the pooled pixel
out_data  out  DATA_W  signed pooled pixel
frame_done  out  1  one-cycle pulse when the last pooled pixel of a frame is accepted

Behaviour:
- Reset (async, rst=1): col=0, row=0, out_valid=0, out_data=0, frame_done=0, mode_q=0. Accumulator contents are don't-care.
- Input acceptance: in_ready = !out_valid || out_ready. A pixel is accepted when in_valid && in_ready.
- Counters: col runs 0..FM_W-1, then wraps to 0 and increments row. row runs 0..FM_H-1, then wraps to 0.
- Frame start: mode is latched into mode_q on the accepted pixel at row=0, col=0. Changes to mode mid-frame are ignored.
- Window position: widx = col/POOL. first = (row%POOL==0 && col%POOL==0). last = (row%POOL==POOL-1 && col%POOL==POOL-1).
- Accumulator, array of FM_W/POOL entries of ACC_W bits:
  - On an accepted pixel with first set: acc[widx] = sign-extended pixel.
  - On any other accepted pixel: acc[widx] = acc[widx] + pixel in average mode, or max(acc[widx], pixel) signed in max mode.
  - Average mode only: for a pixel at col%POOL==0 that is not first, the accumulator still updates normally, continuing the running sum.
- Output generation: on an accepted pixel with last set, the combined value v = op(acc[widx], pixel) is registered on the next edge, and out_valid is set to 1. Latency is 1 cycle from the last window pixel to out_valid.
  - Average: out_data = v >>> (2*log2(POOL)), an arithmetic shift that floors toward negative infinity, truncated to DATA_W (always in range).
  - Max: out_data = v[DATA_W-1:0].
- Output hold: out_valid and out_data stay stable until out_ready is high. out_valid clears on the handshake unless a new result is registered in the same cycle, in which case it stays high with the new data.
- Backpressure: while out_valid && !out_ready, in_ready=0 and no pixel is consumed.
- frame_done: asserts for one cycle, on the cycle after the handshake of the output for window (FM_H/POOL-1, FM_W/POOL-1).
- clear: sets col=0, row=0, out_valid=0 on the next edge, and discards any pending output. clear has priority over a simultaneous input or output handshake.
- Reset mid-frame: identical to clear, but asynchronous. The next accepted pixel is treated as frame pixel (0,0).
- No internal FSM beyond the counters. Back-to-back frames need no idle cycle.

Decomposition:
- cnn_pkg holds the POOL_MODE_AVG/POOL_MODE_MAX constants and the helper function pool_shift(POOL).
- One sub-module, pool_combine: a combinational op(acc, pixel, mode) unit, ACC_W wide. It is reused by a future channel-parallel wrapper.
- Elaboration check: FM_W%POOL==0, FM_H%POOL==0, and POOL in {2,4}, else $fatal.

Test Plan:
- 6x6 ramp 0..35, POOL=2, mode=0, out_ready=1 -> outputs 3,5,7,15,17,19,27,29,31. frame_done pulses once. in_ready stays 1 throughout.
- Same ramp, mode=1 -> outputs 7,9,11,19,21,23,31,33,35.
- Window pixels -1,-2,-3,-4 with remaining pixels 0: avg -> -3 (floor of -2.5); max -> -1. Max-mode window {0x7FFFFFFF, -0x80000000, 0, 0} -> 0x7FFFFFFF.
- out_ready held 0 for 5 cycles when the first output appears -> in_ready=0 during the stall, out_data holds 3, no input lost, and the full frame result still matches the first scenario.
- rst asserted after 15 accepted pixels, then a full ramp frame -> correct 9 outputs. Repeat using clear instead of rst -> same result. mode toggled mid-frame -> no effect.
- POOL=4, FM_W=FM_H=8, ramp 0..63, mode=0 -> outputs 13,17,45,49 (sums 216,280,728,792 >>>4). mode=1 -> 27,31,59,63.
